// File: rtl/jedro_1_pkg.sv
// Shared types and constants for the jedro_1 instruction fetch path.
package jedro_1_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/jedro_1_fetch_buf_if.sv
// ROM read port plus the decoder-facing valid/ready handshake of the fetch buffer.
interface jedro_1_fetch_buf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] jmp_addr;
    logic                  jmp_addr_valid;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  instr_valid;
    logic                  instr_ready;

    modport master (
        input  jmp_addr, jmp_addr_valid, mem_rdata, instr_ready,
        output mem_en, mem_addr, instr, instr_addr, instr_valid
    );

    modport slave (
        output jmp_addr, jmp_addr_valid, mem_rdata, instr_ready,
        input  mem_en, mem_addr, instr, instr_addr, instr_valid
    );
endinterface

// File: rtl/jedro_1_instr_fifo.sv
// Pointer-based FIFO of fetched words; flush empties it in one cycle.
module jedro_1_instr_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = jedro_1_pkg::fetch_entry_t,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        wdata_i,
    output entry_t        rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   count_o
);
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/jedro_1_fetch_buf.sv
// Prefetch stage: sequential ROM fetch with one outstanding read, word FIFO, PC redirect.
module jedro_1_fetch_buf
    import jedro_1_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    jedro_1_fetch_buf_if.master  fb_if
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_pipe_q, addr_pipe_d;
    logic                  inflight_q, inflight_d, discard_q, discard_d;
    logic [PW:0]           count;
    logic [PW+1:0]         credit;
    logic                  full, empty, jmp, issue, push, pop, valid;
    entry_t                wentry, head;

    assign jmp = fb_if.jmp_addr_valid;

    // Credit counts the outstanding read as occupied; a same-cycle pop is ignored.
    assign credit = {1'b0, count} + {{(PW+1){1'b0}}, inflight_q};
    assign issue  = ~rst_i & ~jmp & (credit < (PW+2)'(DEPTH));
    assign push   = inflight_q & ~discard_q;
    assign valid  = ~rst_i & ~empty & ~jmp;
    assign pop    = valid & fb_if.instr_ready;

    assign wentry.instr = fb_if.mem_rdata;
    assign wentry.addr  = addr_pipe_q;

    jedro_1_instr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jmp),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        pc_d        = pc_q;
        addr_pipe_d = addr_pipe_q;
        inflight_d  = issue;
        discard_d   = 1'b0;
        if (jmp) begin
            pc_d      = {fb_if.jmp_addr[ADDR_WIDTH-1:2], 2'b00};
            discard_d = inflight_q;
        end else if (issue) begin
            pc_d        = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            addr_pipe_d = pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= BOOT_ADDR;
            addr_pipe_q <= '0;
            inflight_q  <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            addr_pipe_q <= addr_pipe_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !jmp) assert (!(push && full));
    end

    assign fb_if.mem_en      = issue;
    assign fb_if.mem_addr    = pc_q;
    assign fb_if.instr_valid = valid;
    assign fb_if.instr       = rst_i ? '0 : head.instr;
    assign fb_if.instr_addr  = rst_i ? '0 : head.addr;
endmodule
